serial_subtractor: RTL and testbench

- Bit-serial, multi-cycle subtractor computing `D = A - B - BI` one bit per clock, LSB first, with a borrow flip-flop.
- It is the inverse-direction companion of the team's combinational ripple adder and adder/subtractor.
- It serves datapaths that can trade latency for area, using a start/done handshake toward a controlling FSM.

---
 rtl/serial_sub_pkg.sv | 24 ++
 rtl/full_subtractor.sv | 23 ++
 rtl/serial_subtractor.sv | 140 ++++++++++++++
 tb/tb_serial_subtractor.sv | 187 ++++++++++++++++++
 4 files changed

// File: rtl/serial_sub_pkg.sv
// ---------------------------------------------------------------------------
// serial_sub_pkg
//   Shared types and sizing helpers for the bit-serial subtractor.
//   - state_t : controller states (IDLE, RUN, FIN)
//   - cnt_w() : bit-counter width for a given operand width, $clog2(width)
//   - SUB_CNT_W_DEFAULT : counter width for the default 4-bit operand width
// ---------------------------------------------------------------------------
package serial_sub_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    FIN  = 2'd2
  } state_t;

  localparam int SUB_WIDTH_DEFAULT = 4;
  localparam int SUB_CNT_W_DEFAULT = $clog2(SUB_WIDTH_DEFAULT);

  // Counter width needed to count 0..width-1 (width >= 2, so never 0).
  function automatic int cnt_w(input int width);
    return $clog2(width);
  endfunction

endpackage

// File: rtl/full_subtractor.sv
// ---------------------------------------------------------------------------
// full_subtractor
//   One-bit combinational full subtractor: D = A - B - BI.
//   Ports:
//     A  in  1  minuend bit
//     B  in  1  subtrahend bit
//     BI in  1  borrow-in
//     D  out 1  difference bit
//     BO out 1  borrow-out
// ---------------------------------------------------------------------------
module full_subtractor (
  input  logic A,
  input  logic B,
  input  logic BI,
  output logic D,
  output logic BO
);

  assign D  = A ^ B ^ BI;
  // Borrow when A=0,B=1, or when A==B and a borrow ripples through.
  assign BO = (~A & B) | (~(A ^ B) & BI);

endmodule

// File: rtl/serial_subtractor.sv
// ---------------------------------------------------------------------------
// serial_subtractor
//   Bit-serial subtractor computing D = A - B - BI, one bit per clock, LSB
//   first, with a borrow flip-flop and a START/DONE handshake.
//   Optional feature macro: SERIAL_SUB_OV_EN adds the signed-overflow output.
//   Ports:
//     CLK   in  1      clock, rising edge
//     RST_N in  1      asynchronous active-low reset
//     START in  1      request, accepted on an edge where BUSY=0
//     A     in  WIDTH  minuend   (sampled on the accepting edge)
//     B     in  WIDTH  subtrahend (sampled on the accepting edge)
//     BI    in  1      borrow-in (sampled on the accepting edge)
//     BUSY  out 1      high while in RUN
//     DONE  out 1      one-cycle completion pulse
//     D     out WIDTH  registered difference, held until next completion
//     BO    out 1      registered borrow-out
//     OV    out 1      registered signed overflow (SERIAL_SUB_OV_EN only)
// ---------------------------------------------------------------------------
module serial_subtractor
  import serial_sub_pkg::*;
#(
  parameter int WIDTH = 4
) (
  input  logic             CLK,
  input  logic             RST_N,
  input  logic             START,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  input  logic             BI,
  output logic             BUSY,
  output logic             DONE,
  output logic [WIDTH-1:0] D,
  output logic             BO
`ifdef SERIAL_SUB_OV_EN
  ,
  output logic             OV
`endif
);

  localparam int CNT_W = cnt_w(WIDTH);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(WIDTH - 1);

  state_t           state_reg;
  logic [WIDTH-1:0] a_sh_reg;
  logic [WIDTH-1:0] b_sh_reg;
  logic [WIDTH-2:0] r_sh_reg;   // already-computed result bits, LSB at bit 0 when full
  logic             br_reg;
  logic [CNT_W-1:0] cnt_reg;
  logic [WIDTH-1:0] d_reg;
  logic             bo_reg;

  logic             fs_d;
  logic             fs_bo;
  logic [WIDTH-1:0] r_cat;
  logic             accept;
  logic             last_bit;

  full_subtractor u_fs (
    .A  (a_sh_reg[0]),
    .B  (b_sh_reg[0]),
    .BI (br_reg),
    .D  (fs_d),
    .BO (fs_bo)
  );

  // New bit enters at the MSB; on the final bit r_cat is the complete result,
  // and its upper WIDTH-1 bits are the shifted register contents otherwise.
  assign r_cat    = {fs_d, r_sh_reg};
  assign accept   = START && (state_reg != RUN);
  assign last_bit = (cnt_reg == CNT_LAST);

`ifdef SERIAL_SUB_OV_EN
  logic a_msb_reg;
  logic b_msb_reg;
  logic ov_reg;

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      a_msb_reg <= 1'b0;
      b_msb_reg <= 1'b0;
      ov_reg    <= 1'b0;
    end else if (accept) begin
      a_msb_reg <= A[WIDTH-1];
      b_msb_reg <= B[WIDTH-1];
    end else if (state_reg == RUN && last_bit) begin
      // Overflow only when operand signs differ and the result sign
      // disagrees with the minuend; fs_d is the result MSB on this edge.
      ov_reg <= (a_msb_reg ^ b_msb_reg) & (a_msb_reg ^ fs_d);
    end
  end

  assign OV = ov_reg;
`endif

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      state_reg <= IDLE;
      a_sh_reg  <= '0;
      b_sh_reg  <= '0;
      r_sh_reg  <= '0;
      br_reg    <= 1'b0;
      cnt_reg   <= '0;
      d_reg     <= '0;
      bo_reg    <= 1'b0;
    end else begin
      case (state_reg)
        IDLE, FIN: begin
          if (accept) begin
            a_sh_reg  <= A;
            b_sh_reg  <= B;
            br_reg    <= BI;
            cnt_reg   <= '0;
            state_reg <= RUN;
          end else begin
            state_reg <= IDLE;
          end
        end
        RUN: begin
          a_sh_reg <= {1'b0, a_sh_reg[WIDTH-1:1]};
          b_sh_reg <= {1'b0, b_sh_reg[WIDTH-1:1]};
          r_sh_reg <= r_cat[WIDTH-1:1];
          br_reg   <= fs_bo;
          cnt_reg  <= cnt_reg + CNT_W'(1);
          if (last_bit) begin
            d_reg     <= r_cat;
            bo_reg    <= fs_bo;
            state_reg <= FIN;
          end
        end
        default: state_reg <= IDLE;
      endcase
    end
  end

  assign BUSY = (state_reg == RUN);
  assign DONE = (state_reg == FIN);
  assign D    = d_reg;
  assign BO   = bo_reg;

endmodule

// File: tb/tb_serial_subtractor.sv
// ---------------------------------------------------------------------------
// tb_serial_subtractor
//   Directed-vector bench for serial_subtractor (WIDTH=4). Expected values
//   are hand-computed constants. Define SERIAL_SUB_OV_EN to cover OV as well.
// ---------------------------------------------------------------------------
module tb_serial_subtractor;

  logic       CLK;
  logic       RST_N;
  logic       START;
  logic [3:0] A;
  logic [3:0] B;
  logic       BI;
  logic       BUSY;
  logic       DONE;
  logic [3:0] D;
  logic       BO;
`ifdef SERIAL_SUB_OV_EN
  logic       OV;
`endif

  int n_checks = 0;
  int n_fail   = 0;

  serial_subtractor #(.WIDTH(4)) dut (
    .CLK   (CLK),
    .RST_N (RST_N),
    .START (START),
    .A     (A),
    .B     (B),
    .BI    (BI),
    .BUSY  (BUSY),
    .DONE  (DONE),
    .D     (D),
    .BO    (BO)
`ifdef SERIAL_SUB_OV_EN
    ,
    .OV    (OV)
`endif
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic check_ov(input string tag, input logic eov);
`ifdef SERIAL_SUB_OV_EN
    check_eq(tag, {31'd0, OV}, {31'd0, eov});
`else
    if (eov === 1'bx) $display("note: %s has no OV", tag);
`endif
  endtask

  // One operation: request, scramble operands during RUN, wait for DONE,
  // then check latency, BUSY length, result and (optionally) D holding.
  task automatic run_op(input string tag, input logic [3:0] a, input logic [3:0] b,
                        input logic bi, input logic [3:0] ed, input logic ebo,
                        input logic eov, input logic chk_hold, input logic [3:0] hold_d);
    int  negs;
    int  busy_n;
    bit  seen;
    negs = 0; busy_n = 0; seen = 0;
    @(negedge CLK);
    A = a; B = b; BI = bi; START = 1'b1;
    @(posedge CLK);
    #1;
    START = 1'b0; A = ~a; B = ~b; BI = ~bi;
    for (int i = 0; i < 20 && !seen; i++) begin
      @(negedge CLK);
      negs++;
      if (DONE) seen = 1;
      else begin
        if (BUSY) busy_n++;
        if (chk_hold) check_eq({tag, "_hold"}, {28'd0, D}, {28'd0, hold_d});
      end
    end
    check_eq({tag, "_done_seen"}, {31'd0, seen}, 32'd1);
    check_eq({tag, "_latency"}, negs - 1, 32'd4);
    check_eq({tag, "_busy_len"}, busy_n, 32'd4);
    check_eq({tag, "_busy_at_done"}, {31'd0, BUSY}, 32'd0);
    check_eq({tag, "_d"}, {28'd0, D}, {28'd0, ed});
    check_eq({tag, "_bo"}, {31'd0, BO}, {31'd0, ebo});
    check_ov({tag, "_ov"}, eov);
    $display("op %s: A=%b B=%b BI=%b -> D=%b BO=%b", tag, a, b, bi, D, BO);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int  k;
    bit  seen;
    int  done_hits;
    RST_N = 1'b0; START = 1'b0; A = '0; B = '0; BI = 1'b0;
    repeat (2) @(negedge CLK);
    check_eq("rst_d", {28'd0, D}, 32'd0);
    check_eq("rst_bo", {31'd0, BO}, 32'd0);
    check_eq("rst_busy", {31'd0, BUSY}, 32'd0);
    check_eq("rst_done", {31'd0, DONE}, 32'd0);
    check_ov("rst_ov", 1'b0);
    RST_N = 1'b1;
    @(negedge CLK);

    run_op("op1", 4'b0101, 4'b0001, 1'b0, 4'b0100, 1'b0, 1'b0, 1'b0, 4'b0000);
    run_op("op2", 4'b0001, 4'b0101, 1'b0, 4'b1100, 1'b1, 1'b0, 1'b1, 4'b0100);

    // Back-to-back with START held high; operands change during the first RUN.
    @(negedge CLK);
    A = 4'b0101; B = 4'b0001; BI = 1'b0; START = 1'b1;
    @(posedge CLK);
    #1;
    A = 4'b1000; B = 4'b0011;
    seen = 0;
    for (int i = 0; i < 20 && !seen; i++) begin
      @(negedge CLK);
      if (DONE) seen = 1;
    end
    check_eq("b2b_first_done", {31'd0, seen}, 32'd1);
    check_eq("b2b_first_d", {28'd0, D}, 32'h4);
    check_eq("b2b_first_bo", {31'd0, BO}, 32'd0);
    check_ov("b2b_first_ov", 1'b0);
    @(posedge CLK);
    #1;
    START = 1'b0;
    seen = 0; k = 0;
    for (int i = 0; i < 20 && !seen; i++) begin
      @(negedge CLK);
      k++;
      if (DONE) seen = 1;
    end
    check_eq("b2b_second_done", {31'd0, seen}, 32'd1);
    check_eq("b2b_gap", k, 32'd5);
    check_eq("b2b_second_d", {28'd0, D}, 32'h5);
    check_eq("b2b_second_bo", {31'd0, BO}, 32'd0);
    check_ov("b2b_second_ov", 1'b1);
    $display("op b2b: second D=%b BO=%b gap=%0d", D, BO, k);

    run_op("wrap", 4'b0000, 4'b0000, 1'b1, 4'b1111, 1'b1, 1'b0, 1'b0, 4'b0000);
`ifdef SERIAL_SUB_OV_EN
    run_op("ov1", 4'b0111, 4'b1000, 1'b0, 4'b1111, 1'b1, 1'b1, 1'b0, 4'b0000);
`endif

    // Reset during the second RUN cycle aborts the operation.
    @(negedge CLK);
    A = 4'b0011; B = 4'b0001; BI = 1'b0; START = 1'b1;
    @(posedge CLK);
    #1;
    START = 1'b0;
    @(posedge CLK);
    #2;
    RST_N = 1'b0;
    #1;
    check_eq("midrst_d", {28'd0, D}, 32'd0);
    check_eq("midrst_bo", {31'd0, BO}, 32'd0);
    check_eq("midrst_busy", {31'd0, BUSY}, 32'd0);
    check_ov("midrst_ov", 1'b0);
    @(negedge CLK);
    @(negedge CLK);
    RST_N = 1'b1;
    done_hits = 0;
    for (int i = 0; i < 8; i++) begin
      @(negedge CLK);
      if (DONE || BUSY) done_hits++;
    end
    check_eq("midrst_no_done", done_hits, 32'd0);
    $display("op midrst: aborted, D=%b BO=%b", D, BO);

`ifdef SERIAL_SUB_OV_EN
    run_op("ov2", 4'b0011, 4'b0001, 1'b0, 4'b0010, 1'b0, 1'b0, 1'b0, 4'b0000);
`endif
    run_op("post_rst", 4'b1001, 4'b0100, 1'b0, 4'b0101, 1'b0, 1'b1, 1'b0, 4'b0000);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
